// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: FSM state encoding and counter sizing shared by the serializer.
package piso_serializer_pkg;
  localparam int ST_W = 2;
  localparam int GAP_W = 4;
  typedef enum logic [ST_W-1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1) > GAP_W ? $clog2(width + 1) : GAP_W;
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake in, serial bit stream and frame strobes out.
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] data_in;
  logic data_valid, data_ready, serial_out, serial_valid, frame_start, frame_done, busy;
  modport master (
    output data_in, data_valid,
    input data_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );
  modport slave (
    input data_in, data_valid,
    output data_ready, serial_out, serial_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// piso_serializer_bit_counter: loadable down-counter that parks at zero and flags terminal count.
module piso_serializer_bit_counter #(parameter int CW = 4) (
  input logic clk,
  input logic rst,
  input logic load_i,
  input logic en_i,
  input logic [CW-1:0] val_i,
  output logic [CW-1:0] cnt_o,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? val_i : (en_i && !tc_o) ? cnt_q - 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  assign tc_o = cnt_q == '0;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial stage; define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDLE_GAP = 0
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP > 0 ? IDLE_GAP - 1 : 0);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic so_q, so_d, sv_q, sv_d, fs_q, fs_d, fd_q, fd_d, busy_q, busy_d;
  logic [CW-1:0] cnt;
  logic tc, cnt_load, cnt_en, accept, last, fin;
`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  assign fin = state_q == PARITY;
`else
  assign fin = last;
`endif
  assign last = state_q == SHIFT && tc;
  assign bus.data_ready = !rst && (state_q == IDLE || (fin && IDLE_GAP == 0));
  assign accept = bus.data_valid && bus.data_ready;
  // one counter serves both the bit count and the gap count
  assign cnt_load = accept || (state_d == GAP && state_q != GAP);
  assign cnt_en = state_q == SHIFT || state_q == GAP;
  assign bus.serial_out = so_q;
  assign bus.serial_valid = sv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_done = fd_q;
  assign bus.busy = busy_q;
  piso_serializer_bit_counter #(.CW(CW)) u_cnt (
    .clk,
    .rst,
    .load_i(cnt_load),
    .en_i(cnt_en),
    .val_i(accept ? BIT_LAST : GAP_LAST),
    .cnt_o(cnt),
    .tc_o(tc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      {so_q, sv_q, fs_q, fd_q, busy_q} <= '0;
`ifdef PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      {so_q, sv_q, fs_q, fd_q, busy_q} <= {so_d, sv_d, fs_d, fd_d, busy_d};
`ifdef PISO_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    if (accept) state_d = SHIFT;
    else if (state_q == GAP) state_d = tc ? IDLE : GAP;
`ifdef PISO_PARITY_EN
    else if (last) state_d = PARITY;
`endif
    else if (fin) state_d = IDLE_GAP > 0 ? GAP : IDLE;
  end
  // outputs are computed for the next cycle so every strobe leaves a flop
  always_comb begin
    sh_d = accept ? bus.data_in : state_q == SHIFT ? sh_q << 1 : sh_q;
`ifdef PISO_PARITY_EN
    par_d = accept ? ^bus.data_in : par_q;
    so_d = state_d == PARITY ? par_d : state_d == SHIFT && sh_d[WIDTH-1];
    fd_d = state_d == PARITY;
`else
    so_d = state_d == SHIFT && sh_d[WIDTH-1];
    fd_d = state_d == SHIFT && !accept && cnt == CW'(1);
`endif
    sv_d = state_d == SHIFT || state_d == PARITY;
    fs_d = accept;
    busy_d = state_d != IDLE;
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed stimulus on two serializers (no gap, gap of 2) against a frame-queue model.
module tb_piso_serializer;
  localparam int W = 4;
  localparam int G1 = 2;
`ifdef PISO_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0, fails = 0, cyc = 0;
  int dn0 = 0, vc0 = 0, gb1 = 0, st0 = 0, dc0 = 0;
  logic [31:0] cap0 = '0, cap1 = '0;
  logic [4:0] q0[$], q1[$];
  piso_serializer_if #(.WIDTH(W)) b0 ();
  piso_serializer_if #(.WIDTH(W)) b1 ();
  piso_serializer #(.WIDTH(W), .IDLE_GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  piso_serializer #(.WIDTH(W), .IDLE_GAP(G1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask
  // entry bits: {busy, frame_done, frame_start, serial_valid, serial_out}
  task automatic push_frame(input int d, input logic [W-1:0] w);
    logic [4:0] e;
    logic b;
    for (int i = 0; i < F; i++) begin
      b = (i < W) ? w[W-1-i] : ^w;
      e = {1'b1, i == F - 1, i == 0, 1'b1, b};
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (d == 1) for (int i = 0; i < G1; i++) q1.push_back(5'b10000);
  endtask
  task automatic step(input int d);
    logic [4:0] e, a;
    logic er, ar, v;
    logic [W-1:0] w;
    int sz;
    sz = d == 0 ? q0.size() : q1.size();
    e = 5'b0;
    if (sz > 0) e = d == 0 ? q0[0] : q1[0];
    er = !rst && (sz == 0 || (sz == 1 && e[3]));
    if (d == 0) begin
      a = {b0.busy, b0.frame_done, b0.frame_start, b0.serial_valid, b0.serial_out};
      ar = b0.data_ready; v = b0.data_valid; w = b0.data_in;
    end else begin
      a = {b1.busy, b1.frame_done, b1.frame_start, b1.serial_valid, b1.serial_out};
      ar = b1.data_ready; v = b1.data_valid; w = b1.data_in;
    end
    chk(d == 0 ? "dut0_outputs" : "dut1_outputs", a, e);
    chk(d == 0 ? "dut0_ready" : "dut1_ready", ar, er);
    if (sz > 0) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (rst) begin
      if (d == 0) q0.delete(); else q1.delete();
    end else if (v && er) push_frame(d, w);
  endtask
  always @(negedge clk) begin
    cyc++;
    step(0);
    step(1);
    if (b0.serial_valid) begin cap0 = {cap0[30:0], b0.serial_out}; vc0++; end
    if (b1.serial_valid) cap1 = {cap1[30:0], b1.serial_out};
    if (b0.frame_done) begin dn0++; dc0 = cyc; end
    if (b0.frame_start) st0 = cyc;
    if (b1.busy && !b1.serial_valid) gb1++;
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input int d, input logic [W-1:0] w);
    int n;
    n = 0;
    if (d == 0) begin b0.data_valid = 1'b1; b0.data_in = w; end
    else begin b1.data_valid = 1'b1; b1.data_in = w; end
    do begin @(negedge clk); n++; end while (!(d == 0 ? b0.data_ready : b1.data_ready) && n < 60);
    if (n >= 60) begin
      tests++; fails++;
      $display("FAIL send_timeout dut%0d: data_ready not seen within 60 cycles, required 1", d);
    end
    @(posedge clk); #1;
    if (d == 0) b0.data_valid = 1'b0; else b1.data_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    int s, n0, v0, g;
    b0.data_valid = 1'b0; b0.data_in = '0;
    b1.data_valid = 1'b0; b1.data_in = '0;
    tick(3);
    chk("reset_outputs", {b0.busy, b0.frame_done, b0.frame_start, b0.serial_valid, b0.serial_out}, 0);
    chk("reset_ready", b0.data_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", b0.data_ready, 1);
    // single word
    n0 = dn0;
    send(0, 4'b1011);
    s = cyc;
    tick(F + 2);
    chk("single_start_cycle", st0 - s, 1);
    chk("single_done_cycle", dc0 - s, F);
    chk("single_done_count", dn0 - n0, 1);
`ifdef PISO_PARITY_EN
    chk("single_bits", cap0[4:0], 5'b10111);
`else
    chk("single_sipo", cap0[3:0], 4'b1011);
`endif
    // back-to-back
    v0 = vc0;
    send(0, 4'hA);
    s = cyc;
    send(0, 4'h5);
    tick(F + 2);
    chk("b2b_valid_cycles", vc0 - v0, 2 * F);
    chk("b2b_done_cycle", dc0 - s, 2 * F);
`ifdef PISO_PARITY_EN
    chk("b2b_bits", cap0[9:0], 10'b1010_0_0101_0);
`else
    chk("b2b_bits", cap0[7:0], 8'hA5);
`endif
    // backpressure with data_in changing mid-frame
    n0 = dn0;
    send(0, 4'b1100);
    b0.data_valid = 1'b1; b0.data_in = 4'b0011;
    tick(2);
    b0.data_valid = 1'b0; b0.data_in = 4'b1111;
    tick(F + 3);
    chk("bp_done_count", dn0 - n0, 1);
`ifdef PISO_PARITY_EN
    chk("bp_bits", cap0[4:0], 5'b11000);
`else
    chk("bp_bits", cap0[3:0], 4'b1100);
`endif
    // reset during bit 2
    n0 = dn0;
    send(0, 4'hF);
    tick(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", b0.data_ready, 0);
    tick(1);
    chk("rst_mid_outputs", {b0.busy, b0.frame_done, b0.frame_start, b0.serial_valid, b0.serial_out}, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", b0.data_ready, 1);
    tick(F + 2);
    chk("rst_no_done", dn0 - n0, 0);
`ifdef PISO_PARITY_EN
    v0 = vc0;
    send(0, 4'b0111);
    tick(F + 3);
    chk("parity_bits", cap0[4:0], 5'b01111);
    chk("parity_valid_cycles", vc0 - v0, 5);
`endif
    // gap of two idle cycles between queued words
    g = gb1;
    send(1, 4'h9);
    send(1, 4'h6);
    tick(F + G1 + 4);
    chk("gap_idle_cycles", gb1 - g, 2 * G1);
`ifdef PISO_PARITY_EN
    chk("gap_bits", cap1[9:0], 10'b1001_0_0110_0);
`else
    chk("gap_bits", cap1[7:0], 8'h96);
`endif
    // random traffic on both instances
    repeat (600) begin
      rst = $urandom_range(0, 59) == 0;
      b0.data_valid = 1'($urandom % 2);
      b0.data_in = W'($urandom);
      b1.data_valid = 1'($urandom % 2);
      b1.data_in = W'($urandom);
      tick(1);
    end
    rst = 1'b0;
    b0.data_valid = 1'b0;
    b1.data_valid = 1'b0;
    tick(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
